alu_share_arb: RTL

Round-robin controller that shares the single combinational `ALU` between two requesters, for example the EX stage and a multi-cycle helper unit. It uses a valid/ready handshake on each request port. On a grant it registers the operands, drives the ALU for one evaluation cycle, and captures `Out` into a result register. It returns the result with the requester id through a response handshake, and keeps one operation outstanding at a time.

---
 rtl/alu_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 12 +
 rtl/alu_share_arb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and width defaults for the ALU sharing controller.
package alu_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_OPW   = 4;
  localparam int DEF_POSW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_POSW-1:0]  msb;
    logic [DEF_POSW-1:0]  lsb;
    logic [DEF_OPW-1:0]   op;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the requester not equal to last wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = en & req[0] & (~req[1] | last);
  assign gnt[1] = en & req[1] & (~req[0] | ~last);

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters, one operation in flight.
//   state | meaning
//   IDLE  | no operation; arbiter enabled
//   EXEC  | operands registered on ALU pins for one evaluation cycle
//   RESP  | result held until consumer takes it; arbiter enabled with rsp_ready
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW,
  parameter int POSW  = DEF_POSW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [POSW-1:0]  req0_msb,
  input  logic [POSW-1:0]  req0_lsb,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [POSW-1:0]  req1_msb,
  input  logic [POSW-1:0]  req1_lsb,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [POSW-1:0]  alu_msb,
  output logic [POSW-1:0]  alu_lsb,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [POSW-1:0]  alu_msb_q, alu_msb_d;
  logic [POSW-1:0]  alu_lsb_q, alu_lsb_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;

  logic       arb_en;
  logic [1:0] gnt;
  logic       accept;

  // Gated by reset so nothing looks accepted while the block is held.
  assign arb_en = ~reset & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));

  rr_arb2 u_rr_arb2 (
    .req  (req_valid),
    .en   (arb_en),
    .last (last_q),
    .gnt  (gnt)
  );

  assign accept    = |gnt;
  assign req_ready = gnt;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_msb_d   = alu_msb_q;
    alu_lsb_d   = alu_lsb_q;
    alu_op_d    = alu_op_q;

    case (state_q)
      IDLE: ;
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept in RESP retires the response on the same edge.
    if (accept) begin
      state_d     = EXEC;
      rsp_valid_d = 1'b0;
      id_d        = gnt[1];
      last_d      = gnt[1];
      alu_a_d     = gnt[1] ? req1_a   : req0_a;
      alu_b_d     = gnt[1] ? req1_b   : req0_b;
      alu_msb_d   = gnt[1] ? req1_msb : req0_msb;
      alu_lsb_d   = gnt[1] ? req1_lsb : req0_lsb;
      alu_op_d    = gnt[1] ? req1_op  : req0_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_msb_q   <= '0;
      alu_lsb_q   <= '0;
      alu_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_msb_q   <= alu_msb_d;
      alu_lsb_q   <= alu_lsb_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_msb   = alu_msb_q;
  assign alu_lsb   = alu_lsb_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule
